status_array_ctrl: RTL

Request arbiter and initializer sitting directly upstream of the instruction-cache status array. After reset (and on every flush) it sweeps all status rows to zero, then merges fetch-side lookups and refill-side valid-bit updates into the single registered request stream the status array consumes. It also resolves write-then-read hazards on the same row.

---
 rtl/status_array_ctrl_pkg.sv | 12 +
 rtl/status_array_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/status_array_ctrl_pkg.sv
// Shared definitions for the status-array request controller: FSM state encoding.
package status_array_ctrl_pkg;

    localparam logic STATE_SWEEP = 1'b0;
    localparam logic STATE_RUN   = 1'b1;

    typedef enum logic {
        SWEEP = STATE_SWEEP,
        RUN   = STATE_RUN
    } state_e;

endpackage

// File: rtl/status_array_ctrl.sv
// Zero-sweeps the status array after reset/flush, then merges refill updates and
// fetch lookups into one registered request stream with write-then-read hazard stall.
module status_array_ctrl
    import status_array_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH  = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int ROW_WIDTH  = 8,
    parameter int NUM_BLOCKS = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_lkp_valid,
    input  logic [ADDR_WIDTH-1:0] i_lkp_addr,
    input  logic [TAG_WIDTH-1:0]  i_lkp_tag,
    output logic                  o_lkp_ready,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_addr,
    input  logic [ROW_WIDTH-1:0]  i_upd_data,
    input  logic [NUM_BLOCKS-1:0] i_upd_wmask,
    output logic                  o_upd_ready,
    input  logic                  i_flush,
    input  logic                  i_sa_ready,
    output logic                  o_valid,
    output logic                  o_wen,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [ROW_WIDTH-1:0]  o_data,
    output logic [NUM_BLOCKS-1:0] o_wmask,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic                  o_init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic                  valid_q, valid_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ROW_WIDTH-1:0]  data_q, data_d;
    logic [NUM_BLOCKS-1:0] wmask_q, wmask_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic                  init_done_q, init_done_d;

    logic                  run;
    logic                  hazard;
    logic [ADDR_WIDTH-1:0] sweep_row;

    assign run       = (state_q == RUN);
    assign hazard    = valid_q & wen_q & (addr_q == i_lkp_addr);
    // A pending flush forces the sweep to restart at row 0 on the next advance.
    assign sweep_row = flush_pend_q ? '0 : cnt_q;

    assign o_upd_ready = run & i_sa_ready & ~flush_pend_q;
    assign o_lkp_ready = o_upd_ready & ~i_upd_valid & ~hazard;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q | i_flush;
        valid_d      = valid_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wmask_d      = wmask_q;
        tag_d        = tag_q;
        init_done_d  = init_done_q;

        if (i_sa_ready) begin
            flush_pend_d = 1'b0;
            valid_d      = 1'b0;
            wen_d        = 1'b0;
            addr_d       = '0;
            data_d       = '0;
            wmask_d      = '0;
            tag_d        = '0;

            if (!run || flush_pend_q) begin
                state_d = SWEEP;
                valid_d = 1'b1;
                wen_d   = 1'b1;
                addr_d  = sweep_row;
                wmask_d = '1;
                cnt_d   = sweep_row + ADDR_WIDTH'(1);
                if (i_flush) begin
                    cnt_d = '0;
                end else if (sweep_row == LAST_ROW) begin
                    state_d = RUN;
                end
            end else begin
                flush_pend_d = i_flush;
                if (i_upd_valid) begin
                    valid_d = 1'b1;
                    wen_d   = 1'b1;
                    addr_d  = i_upd_addr;
                    data_d  = i_upd_data;
                    wmask_d = i_upd_wmask;
                end else if (i_lkp_valid && o_lkp_ready) begin
                    valid_d = 1'b1;
                    addr_d  = i_lkp_addr;
                    tag_d   = i_lkp_tag;
                end
            end

            // Done only once RUN has held across an edge, so it lags sweep completion by one.
            init_done_d = run & (state_d == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q      <= SWEEP;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            wmask_q      <= '0;
            tag_q        <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wmask_q      <= wmask_d;
            tag_q        <= tag_d;
            init_done_q  <= init_done_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_wen       = wen_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;
    assign o_wmask     = wmask_q;
    assign o_tag       = tag_q;
    assign o_init_done = init_done_q;

endmodule
